// File: rtl/nonce_scheduler.sv
// nonce_scheduler: shares a nonce sweep across parallel hash cores and funnels their results onto one write port
module nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int NUM_NONCES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             base_nonce,
    input  logic [15:0]             hash_out_addr,
    output logic                    done,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [32*NUM_CORES-1:0] core_hash,
    output logic [NUM_CORES-1:0]    core_ack,
    output logic                    mem_we,
    output logic [15:0]             memory_addr,
    output logic [31:0]             memory_write_data
);
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [31:0] base;
    logic [15:0] addr_base;
    logic [8:0] next_idx, wr_cnt;
    logic [NUM_CORES-1:0] active;
    logic [PW-1:0] rr_ptr, li, gi;
    logic [7:0] tag [NUM_CORES];
    logic launch, grant, last_write;

    assign done = (state == IDLE);

    // pick the lowest idle core to launch and the first finished core at or after rr_ptr to collect
    always_comb begin
        int j;
        j = 0;
        launch = 1'b0;
        li = '0;
        grant = 1'b0;
        gi = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!active[i] && !core_done[i]) begin
                launch = 1'b1;
                li = PW'(i);
            end
        end
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            j = j >= NUM_CORES ? j - NUM_CORES : j;
            if (active[j] && core_done[j]) begin
                grant = 1'b1;
                gi = PW'(j);
            end
        end
        launch = launch && state == RUN && next_idx < 9'(NUM_NONCES);
        grant = grant && state == RUN;
        last_write = grant && wr_cnt == 9'(NUM_NONCES - 1);
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last_write ? IDLE : RUN);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // sweep bookkeeping, launch pulses and result write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            base <= '0;
            addr_base <= '0;
            next_idx <= '0;
            wr_cnt <= '0;
            active <= '0;
            rr_ptr <= '0;
            tag <= '{default: '0};
            core_start <= '0;
            core_nonce <= '0;
            core_ack <= '0;
            mem_we <= 1'b0;
            memory_addr <= '0;
            memory_write_data <= '0;
        end else begin
            core_start <= '0;
            core_ack <= '0;
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                base <= base_nonce;
                addr_base <= hash_out_addr;
                next_idx <= '0;
                wr_cnt <= '0;
                active <= '0;
                rr_ptr <= '0;
            end
            if (launch) begin
                core_start[li] <= 1'b1;
                core_nonce[32*int'(li) +: 32] <= base + 32'(next_idx);
                tag[li] <= next_idx[7:0];
                active[li] <= 1'b1;
                next_idx <= next_idx + 9'd1;
            end
            if (grant) begin
                mem_we <= 1'b1;
                core_ack[gi] <= 1'b1;
                memory_addr <= addr_base + 16'(tag[gi]);
                memory_write_data <= core_hash[32*int'(gi) +: 32];
                active[gi] <= 1'b0;
                rr_ptr <= (gi == PW'(NUM_CORES - 1)) ? '0 : gi + 1'b1;
                wr_cnt <= wr_cnt + 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_nonce_scheduler.sv
// tb_nonce_scheduler: directed sweeps against a behavioural core model with a write/launch scoreboard
module tb_nonce_scheduler;
    localparam int NC = 4;
    localparam int NN = 16;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          core;
    } wr_t;

    typedef struct {
        int          core;
        logic [31:0] nonce;
        int          cyc;
    } ln_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] base_nonce = '0;
    logic [15:0] hash_out_addr = '0;
    logic done, mem_we;
    logic [NC-1:0] core_start, core_done, core_ack;
    logic [32*NC-1:0] core_nonce;
    logic [32*NC-1:0] core_hash = '0;
    logic [15:0] memory_addr;
    logic [31:0] memory_write_data;

    logic [NC-1:0] mdone = '0;
    logic [NC-1:0] spur = '0;
    bit busy [NC];
    int cnt [NC];
    logic [31:0] cn [NC];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int s0 = 0;
    int lat_mode = 0;
    int launches = 0;
    bit ordered = 1'b1;
    logic [31:0] sweep_base = '0;
    wr_t wq [$];
    ln_t lq [$];
    int wcyc [$];
    logic [15:0] waddr [$];

    assign core_done = mdone | spur;

    nonce_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_nonce(base_nonce),
        .hash_out_addr(hash_out_addr),
        .done(done),
        .core_start(core_start),
        .core_nonce(core_nonce),
        .core_done(core_done),
        .core_hash(core_hash),
        .core_ack(core_ack),
        .mem_we(mem_we),
        .memory_addr(memory_addr),
        .memory_write_data(memory_write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int n);
        return lat_mode == 1 ? 13 - n % NC
             : lat_mode == 2 ? (n == 3 ? 3 : n == 0 ? 8 : n < 3 ? 20 : 10)
             : 10;
    endfunction

    // behavioural hash cores: latch nonce on launch, raise done after a latency, drop it on ack
    always @(negedge clk) begin
        if (reset) begin
            mdone = '0;
            for (int i = 0; i < NC; i++) busy[i] = 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_ack[i]) begin
                    chk("ack_to_done_core", 32'(mdone[i]), 32'd1);
                    mdone[i] = 1'b0;
                    busy[i] = 1'b0;
                end else if (core_start[i]) begin
                    chk("launch_core_free", 32'(busy[i] | mdone[i]), 32'd0);
                    busy[i] = 1'b1;
                    cn[i] = core_nonce[32*i +: 32];
                    cnt[i] = lat_of(int'(cn[i] - sweep_base));
                end else if (busy[i] && !mdone[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        chk("nonce_held", core_nonce[32*i +: 32], cn[i]);
                        mdone[i] = 1'b1;
                        core_hash[32*i +: 32] = cn[i] ^ 32'hA5A5A5A5;
                    end
                end
            end
        end
    end

    // launch monitor: compares launches against queued expectations
    always @(negedge clk) begin
        if (!reset && core_start != '0) begin
            chk("launch_onehot", 32'($countones(core_start)), 32'd1);
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    launches++;
                    if (lq.size() > 0) begin
                        ln_t e;
                        e = lq.pop_front();
                        chk("launch_core", 32'(i), 32'(e.core));
                        chk("launch_nonce", core_nonce[32*i +: 32], e.nonce);
                        if (e.cyc >= 0) chk("launch_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // write monitor: pops the scoreboard on every memory write
    always @(negedge clk) begin
        if (!reset && core_ack != '0 && !mem_we) chk("ack_without_write", 32'(core_ack), 32'd0);
        if (!reset && mem_we) begin
            wcyc.push_back(cyc);
            waddr.push_back(memory_addr);
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                wr_t e;
                int k;
                k = ordered ? 0 : -1;
                for (int j = 0; j < wq.size(); j++) if (k < 0 && wq[j].addr == memory_addr) k = j;
                if (k < 0) k = 0;
                e = wq[k];
                wq.delete(k);
                chk("write_addr", 32'(memory_addr), 32'(e.addr));
                chk("write_data", memory_write_data, e.data);
                chk("ack_count", 32'($countones(core_ack)), 32'd1);
                if (e.core >= 0) chk("ack_core", 32'(core_ack), 32'd1 << e.core);
                chk("done_with_write", 32'(done), 32'(wq.size() == 0));
            end
        end
    end

    task automatic run_sweep(input logic [31:0] b, input logic [15:0] a, input int mode, input bit ord);
        lat_mode = mode;
        ordered = ord;
        sweep_base = b;
        wcyc.delete();
        waddr.delete();
        for (int n = 0; n < NN; n++)
            wq.push_back('{a + 16'(n), (b + 32'(n)) ^ 32'hA5A5A5A5, ord ? n % NC : -1});
        @(negedge clk);
        base_nonce = b;
        hash_out_addr = a;
        start = 1'b1;
        s0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_first_launches(input logic [31:0] b);
        for (int k = 0; k < NC; k++) lq.push_back('{k, b + 32'(k), s0 + k + 2});
    endtask

    task automatic wait_empty(input int lim);
        int t;
        t = 0;
        while (wq.size() > 0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("sweep_complete", 32'(wq.size()), 32'd0);
        @(negedge clk);
        chk("done_after_sweep", 32'(done), 32'd1);
    endtask

    initial begin
        int lbefore;
        int t;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_core_ack", 32'(core_ack), 32'd0);
        chk("rst_memory_addr", 32'(memory_addr), 32'd0);
        chk("rst_write_data", memory_write_data, 32'd0);
        chk("rst_core_nonce", core_nonce[31:0] | core_nonce[63:32] | core_nonce[95:64] | core_nonce[127:96], 32'd0);
        reset = 1'b0;

        run_sweep(32'h0000_0000, 16'h0100, 0, 1'b1);
        push_first_launches(32'h0000_0000);
        @(negedge clk);
        chk("done_low_in_run", 32'(done), 32'd0);
        wait_empty(400);

        run_sweep(32'h0000_5000, 16'h0400, 1, 1'b1);
        wait_empty(400);
        chk("simul_writes", 32'(wcyc.size()), 32'(NN));
        if (wcyc.size() == NN) begin
            chk("simul_burst_first", 32'(wcyc[3] - wcyc[0]), 32'd3);
            chk("simul_burst_second", 32'(wcyc[7] - wcyc[4]), 32'd3);
        end

        spur = 4'b0010;
        repeat (4) begin
            @(negedge clk);
            chk("spurious_no_we", 32'(mem_we), 32'd0);
            chk("spurious_no_ack", 32'(core_ack), 32'd0);
        end
        spur = '0;

        run_sweep(32'h0000_2000, 16'h0800, 2, 1'b0);
        push_first_launches(32'h0000_2000);
        lq.push_back('{3, 32'h0000_2004, -1});
        wait_empty(400);
        if (waddr.size() >= 2) begin
            chk("ooo_first_addr", 32'(waddr[0]), 32'h0803);
            chk("ooo_second_addr", 32'(waddr[1]), 32'h0800);
        end else chk("ooo_write_count", 32'(waddr.size()), 32'(NN));

        run_sweep(32'hFFFF_FFFE, 16'hFFFE, 0, 1'b1);
        push_first_launches(32'hFFFF_FFFE);
        wait_empty(400);

        run_sweep(32'h0000_1000, 16'h0200, 0, 1'b1);
        repeat (6) @(negedge clk);
        base_nonce = 32'hDEAD_0000;
        hash_out_addr = 16'h7777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_nonce = 32'h0000_1000;
        hash_out_addr = 16'h0200;
        chk("start_ignored_in_run", 32'(done), 32'd0);
        t = 0;
        while (waddr.size() < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("midrun_writes", 32'(waddr.size()), 32'd5);
        reset = 1'b1;
        wq.delete();
        lq.delete();
        @(negedge clk);
        chk("midrst_done", 32'(done), 32'd1);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_core_ack", 32'(core_ack), 32'd0);
        chk("midrst_core_start", 32'(core_start), 32'd0);
        chk("midrst_memory_addr", 32'(memory_addr), 32'd0);
        chk("midrst_write_data", memory_write_data, 32'd0);
        chk("midrst_core_nonce", core_nonce[31:0] | core_nonce[63:32] | core_nonce[95:64] | core_nonce[127:96], 32'd0);
        reset = 1'b0;
        lbefore = launches;
        repeat (20) @(negedge clk);
        chk("no_launch_after_reset", 32'(launches), 32'(lbefore));
        chk("idle_after_reset", 32'(done), 32'd1);

        run_sweep(32'h0000_0000, 16'h0300, 0, 1'b1);
        push_first_launches(32'h0000_0000);
        wait_empty(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
